// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch_bcd core: FSM state encoding,
// BCD digit width and the digit count of the SS.hh display.
package stopwatch_pkg;

    localparam int              BCD_W      = 4;
    localparam logic [BCD_W-1:0] BCD_MAX   = 4'd9;
    localparam int              NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

endpackage

// File: rtl/bcd_digit_cnt.sv
// Single BCD digit counter (0-9). The carry is combinational so a chain of
// these resolves a full 99.99 -> 00.00 rollover within one clock cycle.
module bcd_digit_cnt
    import stopwatch_pkg::*;
(
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [BCD_W-1:0] digit_o,
    output logic             carry_o
);

    logic [BCD_W-1:0] digit_q, digit_d;

    // Carry out only when this digit is asked to step past 9.
    assign carry_o = inc_i && (digit_q >= BCD_MAX);
    assign digit_o = digit_q;

    // Next digit value: clear has priority over increment.
    always_comb begin
        // NOTE: default assignment first so no path through this block infers a latch.
        digit_d = digit_q;
        if (clr_i) begin
            digit_d = '0;
        end else if (inc_i) begin
            digit_d = (digit_q >= BCD_MAX) ? '0 : digit_q + 4'd1;
        end
    end

    // Digit register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        // NOTE: non-blocking assignments in clocked blocks keep all registers updating on the same edge.
        if (!rstn_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// Stopwatch core: four BCD digits SS.hh, start/stop/clear FSM, prescaled
// tick, synchronised and edge-detected push buttons.
// Optional lap-freeze display enabled with the macro STOPWATCH_LAP_EN.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ = 100_000_000,
    parameter int TICK_HZ  = 100
) (
    input  logic             clk100_i,
    input  logic             rstn_i,
    input  logic             start_stop_i,
    input  logic             clear_i,
    input  logic             lap_i,
    output logic [BCD_W-1:0] hex0_o,
    output logic [BCD_W-1:0] hex1_o,
    output logic [BCD_W-1:0] hex2_o,
    output logic [BCD_W-1:0] hex3_o,
    output logic             running_o,
    output logic             wrap_o
);

    localparam int             DIV       = CLK_FREQ / TICK_HZ;
    localparam int             PW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRESC_MAX = PW'(DIV - 1);

`ifdef STOPWATCH_LAP_EN
    localparam int NUM_BTN = 3;
`else
    localparam int NUM_BTN = 2;
`endif

    logic [NUM_BTN-1:0] btn_raw, sync1_q, sync2_q, prev_q, btn_ev;
    logic               ss_ev, clr_ev;

`ifdef STOPWATCH_LAP_EN
    assign btn_raw = {lap_i, clear_i, start_stop_i};
`else
    assign btn_raw = {clear_i, start_stop_i};
    logic unused_lap;
    assign unused_lap = lap_i;
`endif

    // Two-flop synchroniser followed by a previous-value register per button.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign btn_ev = sync2_q & ~prev_q;
    assign ss_ev  = btn_ev[0];
    assign clr_ev = btn_ev[1];

    state_e state_q, state_d;
    logic   running_q;
    logic   clr_cnt;

    // Next state; start_stop beats clear, clear only acts from PAUSE.
    always_comb begin
        state_d = state_q;
        clr_cnt = 1'b0;
        case (state_q)
            ST_IDLE:  if (ss_ev) state_d = ST_RUN;
            ST_RUN:   if (ss_ev) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (ss_ev) begin
                    state_d = ST_RUN;
                end else if (clr_ev) begin
                    state_d = ST_IDLE;
                    clr_cnt = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // State register with running flag registered alongside it.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == ST_RUN);
        end
    end

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

    // Prescaler advances only in RUN and holds in PAUSE for a seamless resume.
    always_comb begin
        presc_d = presc_q;
        if (clr_cnt) begin
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    logic [NUM_DIGITS:0] carry;
    logic [BCD_W-1:0]    digit [NUM_DIGITS];
    logic [BCD_W-1:0]    disp  [NUM_DIGITS];
    logic                wrap_q;

    assign carry[0] = tick;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_cnt u_digit (
            .clk_i   (clk100_i),
            .rstn_i  (rstn_i),
            .inc_i   (carry[i]),
            .clr_i   (clr_cnt),
            .digit_o (digit[i]),
            .carry_o (carry[i+1])
        );
    end

    // Wrap pulse: carry out of the top digit, i.e. a tick at 99.99.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= carry[NUM_DIGITS];
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic             lap_ev;
    logic             lap_q;
    logic [BCD_W-1:0] frz_q [NUM_DIGITS];

    assign lap_ev = btn_ev[2];

    // Lap freeze: toggled by lap in RUN, released by start_stop or clear.
    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            lap_q <= 1'b0;
            // NOTE: this small snapshot array is reset explicitly; it is flops, not a RAM.
            for (int i = 0; i < NUM_DIGITS; i++) frz_q[i] <= '0;
        end else if (ss_ev || clr_cnt) begin
            lap_q <= 1'b0;
        end else if (lap_ev && (state_q == ST_RUN)) begin
            lap_q <= !lap_q;
            if (!lap_q) begin
                for (int i = 0; i < NUM_DIGITS; i++) frz_q[i] <= digit[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_disp
        assign disp[i] = lap_q ? frz_q[i] : digit[i];
    end
`else
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_disp
        assign disp[i] = digit[i];
    end
`endif

    assign hex0_o    = disp[0];
    assign hex1_o    = disp[1];
    assign hex2_o    = disp[2];
    assign hex3_o    = disp[3];
    assign running_o = running_q;
    assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Bench for stopwatch_bcd: a slow instance (DIV=10) for timing and
// start/stop/clear behaviour and a fast instance (DIV=1) for long carry
// chains and the 99.99 wrap, both driven by the same buttons and compared
// every cycle against a centisecond-count reference model.
module tb_stopwatch_bcd;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2;

    typedef struct packed {
        int st;
        int cnt;    // centiseconds 0..9999
        int presc;
        bit lap;
        int frz;
        bit wrap;
    } mdl_t;

    logic clk = 1'b0, rstn = 1'b0;
    logic ss = 1'b0, clr = 1'b0, lap = 1'b0;
    logic [3:0] s_h0, s_h1, s_h2, s_h3, f_h0, f_h1, f_h2, f_h3;
    logic s_run, s_wrap, f_run, f_wrap;

    int n_checks = 0;
    int n_fail   = 0;

    mdl_t ms, mf;
    bit [2:0] h_ss, h_clr, h_lap;

    always #5 clk = ~clk;

    stopwatch_bcd #(.CLK_FREQ(100), .TICK_HZ(10)) u_slow (
        .clk100_i(clk), .rstn_i(rstn), .start_stop_i(ss), .clear_i(clr), .lap_i(lap),
        .hex0_o(s_h0), .hex1_o(s_h1), .hex2_o(s_h2), .hex3_o(s_h3),
        .running_o(s_run), .wrap_o(s_wrap)
    );

    stopwatch_bcd #(.CLK_FREQ(10), .TICK_HZ(10)) u_fast (
        .clk100_i(clk), .rstn_i(rstn), .start_stop_i(ss), .clear_i(clr), .lap_i(lap),
        .hex0_o(f_h0), .hex1_o(f_h1), .hex2_o(f_h2), .hex3_o(f_h3),
        .running_o(f_run), .wrap_o(f_wrap)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int shown(input mdl_t m);
        return m.lap ? m.frz : m.cnt;
    endfunction

    // One clock of stopwatch behaviour in terms of an integer count.
    function automatic mdl_t step(input mdl_t m, input int div, input bit e_ss,
                                  input bit e_clr, input bit e_lap);
        mdl_t n = m;
        n.wrap = 1'b0;
        if (e_ss) begin
            n.st  = (m.st == S_RUN) ? S_PAUSE : S_RUN;
            n.lap = 1'b0;
        end else if (e_clr && m.st == S_PAUSE) begin
            n.st = S_IDLE; n.cnt = 0; n.presc = 0; n.lap = 1'b0;
        end else if (e_lap && LAP_EN && m.st == S_RUN) begin
            n.lap = !m.lap;
            if (!m.lap) n.frz = m.cnt;
        end
        if (m.st == S_RUN) begin
            n.presc = m.presc + 1;
            if (n.presc == div) begin
                n.presc = 0;
                n.wrap  = (m.cnt == 9999);
                n.cnt   = (m.cnt + 1) % 10000;
            end
        end
        return n;
    endfunction

    // Reference model: a button acts on the third edge after it is first seen high.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ms = '0; mf = '0;
            h_ss = '0; h_clr = '0; h_lap = '0;
        end else begin
            bit e_ss, e_clr, e_lap;
            e_ss  = h_ss[1]  & ~h_ss[2];
            e_clr = h_clr[1] & ~h_clr[2];
            e_lap = h_lap[1] & ~h_lap[2];
            ms = step(ms, 10, e_ss, e_clr, e_lap);
            mf = step(mf, 1,  e_ss, e_clr, e_lap);
            h_ss  = {h_ss[1:0], ss};
            h_clr = {h_clr[1:0], clr};
            h_lap = {h_lap[1:0], lap};
        end
    end

    // Cycle-by-cycle comparison, sampled on the falling edge.
    always @(negedge clk) begin
        check("slow_digits",  {s_h3, s_h2, s_h1, s_h0}, to_bcd(shown(ms)));
        check("slow_running", s_run,  ms.st == S_RUN);
        check("slow_wrap",    s_wrap, ms.wrap);
        check("fast_digits",  {f_h3, f_h2, f_h1, f_h0}, to_bcd(shown(mf)));
        check("fast_running", f_run,  mf.st == S_RUN);
        check("fast_wrap",    f_wrap, mf.wrap);
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle press; returns at the falling edge after the edge it acts on.
    task automatic press(input bit b_ss, input bit b_clr, input bit b_lap);
        ss = b_ss; clr = b_clr; lap = b_lap;
        @(negedge clk);
        ss = 1'b0; clr = 1'b0; lap = 1'b0;
        tick_n(2);
    endtask

    task automatic wait_fast(input int target, input string tag);
        int n = 0;
        while (mf.cnt != target && n < 12000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 12000) check({tag, "_timeout"}, mf.cnt, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] snap;
        tick_n(3);
        rstn = 1'b1;
        tick_n(50);
        check("idle_digits",  {s_h3, s_h2, s_h1, s_h0}, 16'h0000);
        check("idle_running", s_run, 1'b0);
        check("idle_wrap",    s_wrap, 1'b0);

        // Held start_stop: acts on the third edge, exactly once.
        ss = 1'b1;
        @(negedge clk); check("lat_edge1", s_run, 1'b0);
        @(negedge clk); check("lat_edge2", s_run, 1'b0);
        @(negedge clk); check("lat_edge3", s_run, 1'b1);
        tick_n(90);
        check("run_0009", {s_h3, s_h2, s_h1, s_h0}, 16'h0009);
        ss = 1'b0;
        tick_n(9);
        check("pre_0010", {s_h3, s_h2, s_h1, s_h0}, 16'h0009);
        tick_n(1);
        check("run_0010", {s_h3, s_h2, s_h1, s_h0}, 16'h0010);
        check("held_one_event", s_run, 1'b1);

        // Pause at 00.37 with the prescaler at 5.
        tick_n(272);
        press(1, 0, 0);
        check("pause_0037", {s_h3, s_h2, s_h1, s_h0}, 16'h0037);
        check("pause_running", s_run, 1'b0);
        tick_n(20);
        check("pause_frozen", {s_h3, s_h2, s_h1, s_h0}, 16'h0037);

        // start_stop and clear together: resume, prescaler preserved.
        press(1, 1, 0);
        check("both_running", s_run, 1'b1);
        check("both_digits", {s_h3, s_h2, s_h1, s_h0}, 16'h0037);
        tick_n(4);
        check("resume_hold", {s_h3, s_h2, s_h1, s_h0}, 16'h0037);
        tick_n(1);
        check("resume_0038", {s_h3, s_h2, s_h1, s_h0}, 16'h0038);

        // Pause then clear, then restart from a cleared prescaler.
        press(1, 0, 0);
        press(0, 1, 0);
        check("clear_digits",  {s_h3, s_h2, s_h1, s_h0}, 16'h0000);
        check("clear_running", s_run, 1'b0);
        press(0, 1, 0);
        check("clear_in_idle", {s_h3, s_h2, s_h1, s_h0}, 16'h0000);
        press(1, 0, 0);
        tick_n(9);
        check("restart_hold", {s_h3, s_h2, s_h1, s_h0}, 16'h0000);
        tick_n(1);
        check("restart_0001", {s_h3, s_h2, s_h1, s_h0}, 16'h0001);
        press(0, 1, 0);
        check("clear_in_run", s_run, 1'b1);
        tick_n(7);
        check("run_after_clr", {s_h3, s_h2, s_h1, s_h0}, 16'h0002);

        // Lap behaviour (freeze when enabled, ignored otherwise).
        press(0, 0, 1);
        snap = {s_h3, s_h2, s_h1, s_h0};
        tick_n(200);
        check("lap_display", {s_h3, s_h2, s_h1, s_h0}, to_bcd(shown(ms)));
        if (LAP_EN) check("lap_held", {s_h3, s_h2, s_h1, s_h0}, snap);
        press(0, 0, 1);
        check("lap_release", {s_h3, s_h2, s_h1, s_h0}, to_bcd(ms.cnt));

        // Randomised button activity, checked by the per-cycle comparison.
        for (int i = 0; i < 25; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            ss  = (sel == 0) || (sel == 3);
            clr = (sel == 1) || (sel == 3);
            lap = (sel == 2);
            tick_n($urandom_range(1, 4));
            ss = 1'b0; clr = 1'b0; lap = 1'b0;
            tick_n($urandom_range(3, 200));
        end

        // Asynchronous reset mid-count.
        #2 rstn = 1'b0;
        #1 check("async_rst_digits", {s_h3, s_h2, s_h1, s_h0}, 16'h0000);
        check("async_rst_running", s_run, 1'b0);
        tick_n(3);
        rstn = 1'b1;
        tick_n(2);

        // Long carries and wrap on the fast instance.
        press(1, 0, 0);
        wait_fast(999, "w0999");
        check("fast_0999", {f_h3, f_h2, f_h1, f_h0}, 16'h0999);
        @(negedge clk);
        check("fast_1000", {f_h3, f_h2, f_h1, f_h0}, 16'h1000);
        wait_fast(9999, "w9999");
        check("fast_9999", {f_h3, f_h2, f_h1, f_h0}, 16'h9999);
        check("pre_wrap", f_wrap, 1'b0);
        @(negedge clk);
        check("wrap_digits", {f_h3, f_h2, f_h1, f_h0}, 16'h0000);
        check("wrap_pulse", f_wrap, 1'b1);
        check("wrap_running", f_run, 1'b1);
        @(negedge clk);
        check("wrap_one_cycle", f_wrap, 1'b0);
        check("post_wrap", {f_h3, f_h2, f_h1, f_h0}, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
